mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Initiator side of the RV32I data-memory port: the load/store unit between the core's execute stage and the 8 kB memory and peripheral block.
- Accepts one load or store request at a time over a valid/ready handshake and drives the memory port (write_mem, funct3, addresses, write data).
- Captures the memory's half-cycle read data and returns one response per request.
- Misaligned accesses are split into sequential byte accesses, then reassembled with sign or zero extension.

Parameters:
- ALLOW_MISALIGNED, 1: 1 = split misaligned accesses into byte accesses; 0 = reject them with resp_err and no memory access.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (high only in IDLE).
- req_store  in  1  1 = store, 0 = load.
- req_funct3  in  3  RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, LSB-justified.
- resp_valid  out  1  response present; held until resp_ready.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  32  extended load result; 0 for stores.
- resp_err  out  1  misaligned request rejected (ALLOW_MISALIGNED=0 only).
- mem_write  out  1  drives the memory write_mem input.
- mem_funct3  out  3  drives the memory funct3 input.
- mem_write_address  out  32  drives the memory write_address input.
- mem_write_data  out  32  drives the memory write_data input.
- mem_read_address  out  32  drives the memory read_address input.
- mem_read_data  in  32  memory read_data; valid before the posedge that ends the access cycle.

Behaviour:
- Reset (rst_n=0 at posedge):
  - State goes to IDLE.
  - req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_write=0; mem_funct3=3'b010; all mem addresses and mem_write_data = 0.
  - Reset mid-operation abandons the request. No further mem_write is issued; byte writes already committed stay committed.
- Misaligned means: word with addr[1:0]≠0, or half with addr[0]=1. Byte accesses are never misaligned.
- States: IDLE, ACCESS, SPLIT, RESP.
- IDLE:
  - On req_valid&&req_ready, latch the request.
  - Aligned request → ACCESS.
  - Misaligned with ALLOW_MISALIGNED=1 → SPLIT with byte index k=0 and N = 4 (word) or 2 (half).
  - Misaligned with ALLOW_MISALIGNED=0 → RESP with resp_err=1 and no mem_write pulse.
- ACCESS (exactly one cycle):
  - mem_funct3 = latched funct3.
  - Both mem addresses = latched addr.
  - mem_write = req_store.
  - mem_write_data = req_wdata.
  - Load: mem_read_data is registered into resp_rdata at the ending posedge.
  - Next state: RESP.
- SPLIT (N cycles):
  - Cycle k drives address = addr+k, computed mod 2^32 so wrap-around at 0xFFFFFFFF is allowed.
  - Load: mem_funct3=3'b100; mem_read_data[7:0] is captured into byte lane k of an assembly register.
  - Store: mem_funct3=3'b000; mem_write=1; mem_write_data[7:0] = req_wdata byte k.
  - After k=N-1 → RESP. The final result is the assembled value, sign-extended from bit 15 for funct3=001, otherwise as assembled.
- RESP:
  - resp_valid=1; rdata and err are held stable.
  - On resp_ready, clear resp_valid and go to IDLE.
  - The next request can be accepted on the following cycle, never the same cycle.
- Latency from the acceptance edge to resp_valid:
  - aligned: 2 cycles;
  - misaligned: N+1 cycles;
  - rejected: 1 cycle.
- mem_write is high only in ACCESS (store) or SPLIT (store), never in IDLE or RESP.
- Outside an access, mem_funct3 is held at 3'b010.
- Store responses return resp_rdata=0.
- Unmapped addresses read as 0 from memory and are not flagged; peripheral addresses (0xFFFFFFF4..0xFFFFFFFF) are passed through unchanged.

Decomposition:
- Shared package rv32_mem_pkg:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - lsu_state_t enum;
  - a misaligned(funct3, addr) function.
- One sub-module, load_extend: combinational lane select plus sign/zero extension, reused for aligned results.

Test Plan:
- Aligned lw at 0x100 with memory word 0x8899AABB → mem_write never 1; resp_valid 2 cycles after acceptance; rdata=0x8899AABB.
- lb at 0x101 and lbu at 0x101, same word → rdata=0xFFFFFFAA, then 0x000000AA; lh at 0x102 → 0xFFFF8899.
- sw 0x12345678 to 0x103 with ALLOW_MISALIGNED=1 → four mem_write pulses with funct3=000 at 0x103..0x106 carrying 0x78, 0x56, 0x34, 0x12; lw 0x104 then reads 0x00123456 in bits [23:0].
- lh at 0x1FFF (bytes 0x80, 0x01) → two byte reads; rdata=0x00000180. Repeat with bytes 0x01, 0x80 → rdata=0xFFFF8001.
- ALLOW_MISALIGNED=0, sw to 0x102 → resp_err=1 one cycle after acceptance; zero mem_write pulses; memory unchanged.
- Backpressure and reset:
  - Hold resp_ready=0 for 5 cycles → resp_valid and rdata stable, req_ready=0.
  - Assert rst_n=0 during SPLIT at k=1 → next cycle mem_write=0, req_ready=1, resp_valid=0.

Source files
------------

// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I data-memory initiator: funct3 encodings,
// the load/store unit state type and alignment helpers.
package rv32_mem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        SPLIT,
        RESP
    } lsu_state_t;

    // Words need addr[1:0]==0, halves need addr[0]==0; bytes are always aligned.
    function automatic logic misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_W:       return addr_lo != 2'b00;
            F3_H, F3_HU: return addr_lo[0];
            default:    return 1'b0;
        endcase
    endfunction

    // Index of the last byte of a split access (N-1).
    function automatic logic [1:0] split_last_idx(input logic [2:0] funct3);
        return (funct3 == F3_W) ? 2'd3 : 2'd1;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Selects a byte lane out of a 32-bit word and applies the sign or zero
// extension implied by the RV32I load funct3.
module load_extend
    import rv32_mem_pkg::*;
(
    input  logic [31:0] data_i,
    input  logic [1:0]  lane_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [31:0] shifted;

    // Lane shift followed by width-dependent extension.
    always_comb begin
        shifted = data_i >> {lane_i, 3'b000};
        case (funct3_i)
            F3_B:    data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   data_o = {24'h0, shifted[7:0]};
            F3_H:    data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   data_o = {16'h0, shifted[15:0]};
            default: data_o = shifted;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit between execute and the data memory. One request at a
// time; misaligned accesses are either split into byte accesses and
// reassembled, or rejected with resp_err, depending on ALLOW_MISALIGNED.
module mem_access_unit
    import rv32_mem_pkg::*;
#(
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write,
    output logic [2:0]  mem_funct3,
    output logic [31:0] mem_write_address,
    output logic [31:0] mem_write_data,
    output logic [31:0] mem_read_address,
    input  logic [31:0] mem_read_data
);

    lsu_state_t  state_q, state_d;
    logic        store_q, store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  idx_q, idx_d;
    logic [31:0] asm_q, asm_d;
    logic        req_ready_q, req_ready_d;
    logic        resp_valid_q, resp_valid_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        mem_write_q, mem_write_d;
    logic [2:0]  mem_funct3_q, mem_funct3_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;

    logic [31:0] asm_next;
    logic [31:0] ext_in;
    logic [31:0] ext_out;
    logic [1:0]  next_idx;

    // Merge this cycle's byte into the assembly register and pick the word to extend.
    always_comb begin
        asm_next = asm_q;
        asm_next[{idx_q, 3'b000} +: 8] = mem_read_data[7:0];
        ext_in = (state_q == SPLIT) ? asm_next : mem_read_data;
    end

    // The memory already right-justifies load data, so the lane is always 0;
    // split results are assembled LSB-first and only need extension.
    load_extend u_load_extend (
        .data_i   (ext_in),
        .lane_i   (2'b00),
        .funct3_i (funct3_q),
        .data_o   (ext_out)
    );

    // Next-state and registered-output logic for the request/access/response sequence.
    always_comb begin
        state_d      = state_q;
        store_d      = store_q;
        funct3_d     = funct3_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        idx_d        = idx_q;
        asm_d        = asm_q;
        resp_valid_d = resp_valid_q;
        resp_err_d   = resp_err_q;
        resp_rdata_d = resp_rdata_q;
        // The memory port idles as a non-writing word access at address 0.
        mem_write_d  = 1'b0;
        mem_funct3_d = F3_W;
        mem_addr_d   = 32'h0;
        mem_wdata_d  = 32'h0;
        next_idx     = idx_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d  = req_store;
                    funct3_d = req_funct3;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    idx_d    = 2'd0;
                    asm_d    = 32'h0;
                    if (!misaligned(req_funct3, req_addr[1:0])) begin
                        state_d      = ACCESS;
                        mem_write_d  = req_store;
                        mem_funct3_d = req_funct3;
                        mem_addr_d   = req_addr;
                        mem_wdata_d  = req_wdata;
                    end else if (ALLOW_MISALIGNED != 0) begin
                        state_d      = SPLIT;
                        mem_write_d  = req_store;
                        mem_funct3_d = req_store ? F3_B : F3_BU;
                        mem_addr_d   = req_addr;
                        mem_wdata_d  = {24'h0, req_wdata[7:0]};
                    end else begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_rdata_d = 32'h0;
                    end
                end
            end
            ACCESS: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b0;
                resp_rdata_d = store_q ? 32'h0 : ext_out;
            end
            SPLIT: begin
                asm_d = asm_next;
                if (idx_q == split_last_idx(funct3_q)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_rdata_d = store_q ? 32'h0 : ext_out;
                end else begin
                    // Address arithmetic wraps naturally at 2^32.
                    idx_d        = next_idx;
                    mem_write_d  = store_q;
                    mem_funct3_d = store_q ? F3_B : F3_BU;
                    mem_addr_d   = addr_q + {30'h0, next_idx};
                    mem_wdata_d  = {24'h0, wdata_q[{next_idx, 3'b000} +: 8]};
                end
            end
            RESP: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            store_q      <= 1'b0;
            funct3_q     <= F3_W;
            addr_q       <= 32'h0;
            wdata_q      <= 32'h0;
            idx_q        <= 2'd0;
            asm_q        <= 32'h0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'h0;
            mem_write_q  <= 1'b0;
            mem_funct3_q <= F3_W;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            store_q      <= store_d;
            funct3_q     <= funct3_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            idx_q        <= idx_d;
            asm_q        <= asm_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_write_q  <= mem_write_d;
            mem_funct3_q <= mem_funct3_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    assign req_ready         = req_ready_q;
    assign resp_valid        = resp_valid_q;
    assign resp_err          = resp_err_q;
    assign resp_rdata        = resp_rdata_q;
    assign mem_write         = mem_write_q;
    assign mem_funct3        = mem_funct3_q;
    assign mem_write_address = mem_addr_q;
    assign mem_read_address  = mem_addr_q;
    assign mem_write_data    = mem_wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: one splitting instance and one
// rejecting instance share a byte-addressed memory model.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b010;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        resp_ready_a = 1'b0, resp_ready_b = 1'b0;

    logic        req_ready_a, resp_valid_a, resp_err_a, mem_write_a;
    logic [2:0]  mem_funct3_a;
    logic [31:0] resp_rdata_a, mem_waddr_a, mem_wdata_a, mem_raddr_a;
    logic [31:0] mem_rdata_a = 32'h0;

    logic        req_ready_b, resp_valid_b, resp_err_b, mem_write_b;
    logic [2:0]  mem_funct3_b;
    logic [31:0] resp_rdata_b, mem_waddr_b, mem_wdata_b, mem_raddr_b;
    logic [31:0] mem_rdata_b = 32'h0;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ALLOW_MISALIGNED(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_a), .resp_ready(resp_ready_a), .resp_rdata(resp_rdata_a),
        .resp_err(resp_err_a), .mem_write(mem_write_a), .mem_funct3(mem_funct3_a),
        .mem_write_address(mem_waddr_a), .mem_write_data(mem_wdata_a),
        .mem_read_address(mem_raddr_a), .mem_read_data(mem_rdata_a)
    );

    mem_access_unit #(.ALLOW_MISALIGNED(0)) dut_rej (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_store(req_store),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid_b), .resp_ready(resp_ready_b), .resp_rdata(resp_rdata_b),
        .resp_err(resp_err_b), .mem_write(mem_write_b), .mem_funct3(mem_funct3_b),
        .mem_write_address(mem_waddr_b), .mem_write_data(mem_wdata_b),
        .mem_read_address(mem_raddr_b), .mem_read_data(mem_rdata_b)
    );

    // ---------------- memory model ----------------
    logic [7:0] mem [int unsigned];

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [2:0]  f3;
    } wr_t;
    wr_t wlog[$];
    int  b_writes = 0;

    function automatic logic [7:0] rd8(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 8'h00;
    endfunction

    function automatic logic [31:0] mem_read(input logic [2:0] f3, input logic [31:0] a);
        logic [7:0] b0, b1, b2, b3;
        b0 = rd8(a); b1 = rd8(a + 32'd1); b2 = rd8(a + 32'd2); b3 = rd8(a + 32'd3);
        case (f3)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b100:  return {24'h0, b0};
            3'b001:  return {{16{b1[7]}}, b1, b0};
            3'b101:  return {16'h0, b1, b0};
            default: return {b3, b2, b1, b0};
        endcase
    endfunction

    task automatic mem_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        mem[a] = d[7:0];
        if (f3 == 3'b001 || f3 == 3'b010) mem[a + 32'd1] = d[15:8];
        if (f3 == 3'b010) begin
            mem[a + 32'd2] = d[23:16];
            mem[a + 32'd3] = d[31:24];
        end
    endtask

    always @(posedge clk) begin
        if (mem_write_a) begin
            mem_store(mem_funct3_a, mem_waddr_a, mem_wdata_a);
            wlog.push_back('{mem_waddr_a, mem_wdata_a, mem_funct3_a});
        end
        if (mem_write_b) begin
            mem_store(mem_funct3_b, mem_waddr_b, mem_wdata_b);
            b_writes++;
        end
    end

    // Read data settles half a cycle after the address.
    always @(negedge clk) begin
        mem_rdata_a = mem_read(mem_funct3_a, mem_raddr_a);
        mem_rdata_b = mem_read(mem_funct3_b, mem_raddr_b);
    end

    // ---------------- helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic rdy(input int w);  return (w == 0) ? req_ready_a : req_ready_b; endfunction
    function automatic logic rv(input int w);   return (w == 0) ? resp_valid_a : resp_valid_b; endfunction
    function automatic logic rerr(input int w); return (w == 0) ? resp_err_a : resp_err_b; endfunction
    function automatic logic [31:0] rdat(input int w); return (w == 0) ? resp_rdata_a : resp_rdata_b; endfunction
    function automatic logic mw(input int w);   return (w == 0) ? mem_write_a : mem_write_b; endfunction
    function automatic logic [2:0] mf3(input int w); return (w == 0) ? mem_funct3_a : mem_funct3_b; endfunction

    // Present a request, wait for acceptance, and count cycles until resp_valid
    // (the acceptance cycle counts as cycle 0, so the first cycle after it is 1).
    task automatic issue(input int w, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd, output int lat);
        int guard;
        @(negedge clk);
        req_store = st; req_funct3 = f3; req_addr = a; req_wdata = wd;
        if (w == 0) req_valid_a = 1'b1; else req_valid_b = 1'b1;
        guard = 0;
        while (!rdy(w) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20) chk("req_ready_timeout", 32'(rdy(w)), 32'd1);
        @(negedge clk);
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        lat = 1;
        while (!rv(w) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Complete the response handshake, checking the memory port is idle meanwhile.
    task automatic finish_resp(input int w);
        chk("resp_mem_write_idle", 32'(mw(w)), 32'd0);
        chk("resp_mem_funct3_idle", 32'(mf3(w)), 32'd2);
        if (w == 0) resp_ready_a = 1'b1; else resp_ready_b = 1'b1;
        @(negedge clk);
        resp_ready_a = 1'b0; resp_ready_b = 1'b0;
        chk("resp_valid_cleared", 32'(rv(w)), 32'd0);
        chk("req_ready_after_resp", 32'(rdy(w)), 32'd1);
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
        int          lat;
        int          nwr;
    } vec_t;

    vec_t vecs[17];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        logic [31:0] snap, tmp, exp_a, exp_d;
        logic [2:0]  exp_f;
        logic        mis;

        // Memory contents: word 0x8899AABB at 0x100 plus split-half test bytes.
        mem[32'h100] = 8'hBB; mem[32'h101] = 8'hAA; mem[32'h102] = 8'h99; mem[32'h103] = 8'h88;
        mem[32'h1FFF] = 8'h80; mem[32'h2000] = 8'h01;
        mem[32'h3001] = 8'h01; mem[32'h3002] = 8'h80;

        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,          32'h8899AABB, 2, 0};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,          32'hFFFFFFAA, 2, 0};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0101, 32'h0,          32'h000000AA, 2, 0};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,          32'hFFFF8899, 2, 0};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_0102, 32'h0,          32'h00008899, 2, 0};
        vecs[5]  = '{1'b1, 3'b010, 32'h0000_0103, 32'h12345678,   32'h00000000, 5, 4};
        vecs[6]  = '{1'b0, 3'b010, 32'h0000_0104, 32'h0,          32'h00123456, 2, 0};
        vecs[7]  = '{1'b0, 3'b010, 32'h0000_0103, 32'h0,          32'h12345678, 5, 0};
        vecs[8]  = '{1'b0, 3'b001, 32'h0000_1FFF, 32'h0,          32'h00000180, 3, 0};
        vecs[9]  = '{1'b0, 3'b001, 32'h0000_3001, 32'h0,          32'hFFFF8001, 3, 0};
        vecs[10] = '{1'b0, 3'b101, 32'h0000_3001, 32'h0,          32'h00008001, 3, 0};
        vecs[11] = '{1'b1, 3'b001, 32'h0000_2001, 32'h0000BEEF,   32'h00000000, 3, 2};
        vecs[12] = '{1'b0, 3'b001, 32'h0000_2001, 32'h0,          32'hFFFFBEEF, 3, 0};
        vecs[13] = '{1'b1, 3'b010, 32'hFFFF_FFFE, 32'hCAFEF00D,   32'h00000000, 5, 4};
        vecs[14] = '{1'b0, 3'b010, 32'h0000_0000, 32'h0,          32'h0000CAFE, 2, 0};
        vecs[15] = '{1'b1, 3'b000, 32'h0000_0105, 32'h0000005A,   32'h00000000, 2, 1};
        vecs[16] = '{1'b0, 3'b000, 32'h0000_0105, 32'h0,          32'h0000005A, 2, 0};

        // ---- reset state ----
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", 32'(req_ready_a), 32'd1);
        chk("rst_resp_valid", 32'(resp_valid_a), 32'd0);
        chk("rst_resp_err", 32'(resp_err_a), 32'd0);
        chk("rst_resp_rdata", resp_rdata_a, 32'h0);
        chk("rst_mem_write", 32'(mem_write_a), 32'd0);
        chk("rst_mem_funct3", 32'(mem_funct3_a), 32'd2);
        chk("rst_mem_waddr", mem_waddr_a, 32'h0);
        chk("rst_mem_raddr", mem_raddr_a, 32'h0);
        chk("rst_mem_wdata", mem_wdata_a, 32'h0);
        rst_n = 1'b1;
        $display("txn reset: checked idle outputs");

        // ---- backpressure: hold resp_ready low with a new request pending ----
        wlog.delete();
        issue(0, 1'b0, 3'b010, 32'h100, 32'h0, lat);
        chk("bp_latency", 32'(lat), 32'd2);
        req_store = 1'b0; req_funct3 = 3'b000; req_addr = 32'h101; req_wdata = 32'h0;
        req_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_resp_valid_held", 32'(resp_valid_a), 32'd1);
            chk("bp_rdata_held", resp_rdata_a, 32'h8899AABB);
            chk("bp_req_ready_low", 32'(req_ready_a), 32'd0);
        end
        resp_ready_a = 1'b1;
        @(negedge clk);
        resp_ready_a = 1'b0;
        chk("bp_resp_valid_cleared", 32'(resp_valid_a), 32'd0);
        chk("bp_req_ready_idle", 32'(req_ready_a), 32'd1);
        @(negedge clk);
        req_valid_a = 1'b0;
        lat = 1;
        while (!resp_valid_a && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        chk("bp_next_latency", 32'(lat), 32'd2);
        chk("bp_next_rdata", resp_rdata_a, 32'hFFFFFFAA);
        finish_resp(0);
        chk("bp_no_writes", 32'(wlog.size()), 32'd0);
        $display("txn backpressure: lw 0x100 held 5 cycles, then lb 0x101 rdata=%h", resp_rdata_a);

        // ---- rejecting instance ----
        b_writes = 0;
        snap = mem_read(3'b010, 32'h102);
        issue(1, 1'b1, 3'b010, 32'h102, 32'hDEADBEEF, lat);
        chk("rej_sw_latency", 32'(lat), 32'd1);
        chk("rej_sw_err", 32'(resp_err_b), 32'd1);
        chk("rej_sw_rdata", resp_rdata_b, 32'h0);
        finish_resp(1);
        chk("rej_sw_no_writes", 32'(b_writes), 32'd0);
        chk("rej_sw_mem_unchanged", mem_read(3'b010, 32'h102), snap);
        $display("txn reject: sw 0x102 err=1 writes=%0d", b_writes);
        issue(1, 1'b0, 3'b001, 32'h101, 32'h0, lat);
        chk("rej_lh_err", 32'(resp_err_b), 32'd1);
        chk("rej_lh_latency", 32'(lat), 32'd1);
        finish_resp(1);
        issue(1, 1'b0, 3'b010, 32'h100, 32'h0, lat);
        chk("rej_lw_aligned_err", 32'(resp_err_b), 32'd0);
        chk("rej_lw_aligned_rdata", resp_rdata_b, 32'h8899AABB);
        chk("rej_lw_aligned_latency", 32'(lat), 32'd2);
        finish_resp(1);
        $display("txn reject: lh 0x101 rejected, lw 0x100 rdata=%h", resp_rdata_b);

        // ---- table-driven vectors on the splitting instance ----
        for (int i = 0; i < 17; i++) begin
            wlog.delete();
            issue(0, vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata, lat);
            chk($sformatf("v%0d_rdata", i), resp_rdata_a, vecs[i].exp);
            chk($sformatf("v%0d_err", i), 32'(resp_err_a), 32'd0);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
            finish_resp(0);
            chk($sformatf("v%0d_write_count", i), 32'(wlog.size()), 32'(vecs[i].nwr));
            mis = (vecs[i].f3 == 3'b010 && vecs[i].addr[1:0] != 2'b00) ||
                  (vecs[i].f3 == 3'b001 && vecs[i].addr[0]);
            for (int j = 0; j < wlog.size() && j < vecs[i].nwr; j++) begin
                if (mis) begin
                    tmp   = vecs[i].wdata >> (8 * j);
                    exp_a = vecs[i].addr + 32'(j);
                    exp_d = {24'h0, tmp[7:0]};
                    exp_f = 3'b000;
                end else begin
                    exp_a = vecs[i].addr;
                    exp_d = vecs[i].wdata;
                    exp_f = vecs[i].f3;
                end
                chk($sformatf("v%0d_w%0d_addr", i, j), wlog[j].addr, exp_a);
                chk($sformatf("v%0d_w%0d_data", i, j), wlog[j].data, exp_d);
                chk($sformatf("v%0d_w%0d_funct3", i, j), 32'(wlog[j].f3), 32'(exp_f));
            end
            $display("txn %0d: st=%0b f3=%03b addr=%h rdata=%h lat=%0d writes=%0d",
                     i, vecs[i].st, vecs[i].f3, vecs[i].addr, resp_rdata_a, lat, wlog.size());
        end

        // ---- reset during a split store at byte index 1 ----
        wlog.delete();
        @(negedge clk);
        req_store = 1'b1; req_funct3 = 3'b010; req_addr = 32'h201; req_wdata = 32'hA1B2C3D4;
        req_valid_a = 1'b1;
        @(negedge clk);
        req_valid_a = 1'b0;
        @(negedge clk);
        chk("mid_k1_mem_write", 32'(mem_write_a), 32'd1);
        chk("mid_k1_addr", mem_waddr_a, 32'h202);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_mem_write", 32'(mem_write_a), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready_a), 32'd1);
        chk("mid_rst_resp_valid", 32'(resp_valid_a), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rst_committed_writes", 32'(wlog.size()), 32'd2);
        chk("mid_rst_byte3_untouched", 32'(rd8(32'h203)), 32'd0);
        issue(0, 1'b0, 3'b010, 32'h200, 32'h0, lat);
        chk("mid_rst_readback", resp_rdata_a, 32'h00C3D400);
        chk("mid_rst_readback_latency", 32'(lat), 32'd2);
        finish_resp(0);
        $display("txn mid-split reset: committed=%0d readback=%h", 2, resp_rdata_a);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
